// File: rtl/matrix_stream_pkg.sv
// Shared opcode values, opcode classification helpers and FSM state encoding
// for the matrix stream processor.
package matrix_stream_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ANDC = 4'd6;
    localparam logic [3:0] OP_XORC = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_ROR;
    endfunction

    // Illegal opcodes skip the B phase as well, so they count as unary.
    function automatic logic is_unary(input logic [3:0] op);
        return op >= OP_ANDC;
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Combinational elementwise operator: one W-bit result from a, b, the captured
// constant c and the opcode. Illegal opcodes yield zero.
module matrix_elem_alu
    import matrix_stream_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    input  logic [3:0]   op_i,
    output logic [W-1:0] result_o
);

    localparam int SW = $clog2(W);

    logic [SW-1:0]  sh;
    logic [2*W-1:0] rot;

    always_comb begin
        sh       = c_i[SW-1:0];
        // Shifting the doubled word right leaves the rotated value in the low half.
        rot      = {a_i, a_i} >> sh;
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_MUL:  result_o = a_i * b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_ANDC: result_o = a_i & c_i;
            OP_XORC: result_o = a_i ^ c_i;
            OP_SHL:  result_o = a_i << sh;
            OP_SHR:  result_o = a_i >> sh;
            OP_ROR:  result_o = rot[W-1:0];
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/matrix_stream_processor.sv
// Loads matrices A (and B for binary ops) over a valid/ready stream, then drains
// DEPTH elementwise results one per accepted output handshake.
module matrix_stream_processor
    import matrix_stream_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] constant,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         err
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  out_idx_q, out_idx_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   const_q, const_d;
    logic           err_q, err_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [W-1:0]   mem_a_q [DEPTH];
    logic [W-1:0]   mem_b_q [DEPTH];

    logic           in_xfer, out_xfer;
    logic           wr_a, wr_b, load_out;
    logic [CW-1:0]  alu_idx;
    logic [W-1:0]   alu_res;

    assign in_ready  = (state_q != DRAIN);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (out_idx_q == LAST);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign out_data  = out_data_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        out_idx_d = out_idx_q;
        op_d      = op_q;
        const_d   = const_q;
        err_d     = err_q;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        load_out  = 1'b0;
        alu_idx   = out_idx_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    op_d    = opcode;
                    const_d = constant;
                    err_d   = !is_legal(opcode);
                    wr_a    = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                if (in_xfer) begin
                    wr_a = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (is_unary(op_q)) begin
                            state_d   = DRAIN;
                            out_idx_d = '0;
                            alu_idx   = '0;
                            load_out  = 1'b1;
                        end else begin
                            state_d = LOAD_B;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (in_xfer) begin
                    wr_b = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d     = '0;
                        state_d   = DRAIN;
                        out_idx_d = '0;
                        alu_idx   = '0;
                        load_out  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    if (out_idx_q == LAST) begin
                        state_d   = IDLE;
                        out_idx_d = '0;
                    end else begin
                        out_idx_d = out_idx_q + CW'(1);
                        load_out  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    matrix_elem_alu #(.W(W)) u_alu (
        .a_i      (mem_a_q[alu_idx]),
        .b_i      (mem_b_q[alu_idx]),
        .c_i      (const_q),
        .op_i     (op_q),
        .result_o (alu_res)
    );

    assign out_data_d = load_out ? alu_res : out_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            out_idx_q  <= '0;
            op_q       <= '0;
            const_q    <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_idx_q  <= out_idx_d;
            op_q       <= op_d;
            const_q    <= const_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            if (wr_a) mem_a_q[cnt_q] <= in_data;
            if (wr_b) mem_b_q[cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_matrix_stream_processor.sv
// Directed and randomized transactions for matrix_stream_processor, checked
// against a per-element arithmetic reference model.
module tb_matrix_stream_processor;

    localparam int W     = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  constant;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          err;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] va   [DEPTH];
    logic [W-1:0] vb   [DEPTH];
    logic [W-1:0] vexp [DEPTH];

    matrix_stream_processor #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .constant  (constant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c);
        int unsigned sh;
        logic [63:0] prod;
        logic [63:0] wide;
        sh = c % 32;
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  begin prod = 64'(a) * 64'(b); return prod[31:0]; end
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return a & c;
            7:  return a ^ c;
            8:  return a << sh;
            9:  return a >> sh;
            10: begin
                wide = {32'd0, a} << (32 - sh);
                return (a >> sh) | wide[31:0] | wide[63:32];
            end
            default: return '0;
        endcase
    endfunction

    // Sends n_a words of va then n_b words of vb with random valid gaps.
    task automatic send(input int n_a, input int n_b, input logic [3:0] op, input logic [W-1:0] c);
        int  sent  = 0;
        int  guard = 0;
        int  total = n_a + n_b;
        logic xfer;
        while (sent < total && guard < 1000) begin
            @(negedge clk);
            guard++;
            check("in_ready_load", {31'd0, in_ready}, 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_data  = (sent < n_a) ? va[sent] : vb[sent - n_a];
            end
            if (sent == 0) begin
                opcode   = op;
                constant = c;
            end else begin
                opcode   = 4'($urandom);
                constant = $urandom;
            end
            xfer = in_valid && in_ready;
            @(posedge clk);
            if (xfer) sent++;
        end
        check("send_count", sent, total);
    endtask

    task automatic drain(input int stall_pct, input logic exp_err);
        int k     = 0;
        int guard = 0;
        while (k < DEPTH && guard < 400) begin
            @(negedge clk);
            guard++;
            check("out_valid", {31'd0, out_valid}, 32'd1);
            check("out_data", out_data, vexp[k]);
            check("out_last", {31'd0, out_last}, (k == DEPTH - 1) ? 32'd1 : 32'd0);
            check("in_ready_drain", {31'd0, in_ready}, 32'd0);
            check("busy_drain", {31'd0, busy}, 32'd1);
            check("err", {31'd0, err}, {31'd0, exp_err});
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            @(posedge clk);
            if (out_ready) k++;
        end
        check("drain_count", k, DEPTH);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_after", {31'd0, out_valid}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("out_last_after", {31'd0, out_last}, 32'd0);
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [W-1:0] c, input int stall_pct);
        int n_b;
        n_b = (op <= 4'd5) ? DEPTH : 0;
        for (int i = 0; i < DEPTH; i++) vexp[i] = ref_op(int'(op), va[i], vb[i], c);
        send(DEPTH, n_b, op, c);
        drain(stall_pct, op > 4'd10);
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        opcode    = '0;
        constant  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        // ADD: A[i]=i, B[i]=100
        for (int i = 0; i < DEPTH; i++) begin va[i] = i; vb[i] = 100; end
        run_txn(4'd0, 32'd0, 0);
        check("add_w0_model", vexp[0], 32'd100);

        // SUB wrap
        for (int i = 0; i < DEPTH; i++) begin va[i] = 0; vb[i] = 1; end
        run_txn(4'd1, 32'd0, 0);

        // MUL overflow to zero
        for (int i = 0; i < DEPTH; i++) begin va[i] = 32'h10000; vb[i] = 32'h10000; end
        run_txn(4'd2, 32'd0, 0);

        // SHL unary, no B phase
        for (int i = 0; i < DEPTH; i++) begin va[i] = 1; vb[i] = $urandom; end
        run_txn(4'd8, 32'd4, 0);

        // Random data for every legal op with 50% output backpressure
        for (int r = 0; r < 22; r++) begin
            for (int i = 0; i < DEPTH; i++) begin va[i] = $urandom; vb[i] = $urandom; end
            run_txn(4'(r % 11), $urandom, 50);
        end

        // Illegal opcode, then a clean ADD clears err
        for (int i = 0; i < DEPTH; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        run_txn(4'd15, $urandom, 30);
        for (int i = 0; i < DEPTH; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        run_txn(4'd0, 32'd0, 30);

        // Reset in the middle of LOAD_B, then a full XOR run
        for (int i = 0; i < DEPTH; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        send(DEPTH, 3, 4'd5, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_out_last", {31'd0, out_last}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin va[i] = $urandom; vb[i] = $urandom; end
        run_txn(4'd5, 32'd0, 50);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
